// File: rtl/pwm_cfg_sequencer.sv
// APB master that writes period, duty and control for each selected PWM channel.
// Optional readback verification of every write is enabled by defining PWM_CFG_VERIFY_EN.
module pwm_cfg_sequencer #(
  parameter int          NUM_CHANNELS  = 4,
  parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
  parameter int          REGS_PER_CHAN = 3
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [NUM_CHANNELS-1:0]    chan_mask,
  input  logic [NUM_CHANNELS*32-1:0] period_in,
  input  logic [NUM_CHANNELS*32-1:0] duty_in,
  input  logic [NUM_CHANNELS*32-1:0] control_in,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [31:0]                paddr,
  output logic [31:0]                pwdata,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  input  logic [31:0]                prdata
);

  localparam int CW = $clog2(NUM_CHANNELS) + 1;
  localparam int IW = $clog2(REGS_PER_CHAN);
  localparam logic [IW-1:0] LAST_IDX = IW'(REGS_PER_CHAN - 1);

`ifdef PWM_CFG_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RSETUP, RACCESS, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
`endif

  state_t                    state_reg;
  logic [CW-1:0]             ch_reg;
  logic [IW-1:0]             idx_reg;
  logic [NUM_CHANNELS-1:0]   mask_reg;
  logic [NUM_CHANNELS*32-1:0] period_reg, duty_reg, control_reg;
  logic                      busy_reg, done_reg, psel_reg, penable_reg, pwrite_reg;
  logic [31:0]               paddr_reg, pwdata_reg;

  logic [CW-1:0] first_ch, adv_ch, nxt_ch;
  logic [IW-1:0] adv_idx;
  logic          adv_done, nxt_found;
  logic [31:0]   first_data, adv_data;

  function automatic logic [31:0] addr_of(input logic [CW-1:0] c, input logic [IW-1:0] x);
    addr_of = BASE_ADDR + ((32'(c) * 32'(REGS_PER_CHAN) + 32'(x)) << 2);
  endfunction

  // Lowest requested channel, taken straight from the live inputs at start.
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (chan_mask[i]) first_ch = CW'(i);
  end

  always_comb begin
    first_data = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (first_ch == CW'(i)) first_data = period_in[i*32 +: 32];
  end

  // Next register to write: bump the index, or hop to the next set channel above ch.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = ch_reg;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (!nxt_found && CW'(i) > ch_reg && mask_reg[i]) begin
        nxt_found = 1'b1;
        nxt_ch    = CW'(i);
      end
    adv_ch   = ch_reg;
    adv_idx  = idx_reg + IW'(1);
    adv_done = 1'b0;
    if (idx_reg == LAST_IDX) begin
      adv_idx = '0;
      if (nxt_found) adv_ch = nxt_ch;
      else           adv_done = 1'b1;
    end
  end

  always_comb begin
    adv_data = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (adv_ch == CW'(i)) begin
        if (adv_idx == IW'(0))      adv_data = period_reg[i*32 +: 32];
        else if (adv_idx == IW'(1)) adv_data = duty_reg[i*32 +: 32];
        else                        adv_data = control_reg[i*32 +: 32];
      end
  end

`ifdef PWM_CFG_VERIFY_EN
  logic err_reg;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      idx_reg     <= '0;
      mask_reg    <= '0;
      period_reg  <= '0;
      duty_reg    <= '0;
      control_reg <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
`ifdef PWM_CFG_VERIFY_EN
      err_reg     <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy_reg <= 1'b1;
`ifdef PWM_CFG_VERIFY_EN
            err_reg  <= 1'b0;
`endif
            if (chan_mask != '0) begin
              mask_reg    <= chan_mask;
              period_reg  <= period_in;
              duty_reg    <= duty_in;
              control_reg <= control_in;
              ch_reg      <= first_ch;
              idx_reg     <= '0;
              psel_reg    <= 1'b1;
              penable_reg <= 1'b0;
              pwrite_reg  <= 1'b1;
              paddr_reg   <= addr_of(first_ch, '0);
              pwdata_reg  <= first_data;
              state_reg   <= SETUP;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
`ifdef PWM_CFG_VERIFY_EN
        ACCESS: begin
          penable_reg <= 1'b0;
          pwrite_reg  <= 1'b0;
          state_reg   <= RSETUP;
        end
        RSETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= RACCESS;
        end
        RACCESS: begin
          if (prdata != pwdata_reg) err_reg <= 1'b1;
`else
        ACCESS: begin
`endif
          if (adv_done) begin
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end else begin
            ch_reg      <= adv_ch;
            idx_reg     <= adv_idx;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b1;
            paddr_reg   <= addr_of(adv_ch, adv_idx);
            pwdata_reg  <= adv_data;
            state_reg   <= SETUP;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign psel    = psel_reg;
  assign penable = penable_reg;
  assign pwrite  = pwrite_reg;
  assign paddr   = paddr_reg;
  assign pwdata  = pwdata_reg;

`ifdef PWM_CFG_VERIFY_EN
  assign err = err_reg;
`else
  // Readback data has no consumer without verification.
  logic unused_prdata;
  assign unused_prdata = ^prdata;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer: records APB writes per sequence and compares
// them, plus timing and status flags, against hand-derived expectations.
module tb_pwm_cfg_sequencer;

  localparam int N = 4;
`ifdef PWM_CFG_VERIFY_EN
  localparam int CPR = 4;
`else
  localparam int CPR = 2;
`endif

  logic         clk = 1'b0;
  logic         n_rst, start;
  logic [N-1:0] chan_mask;
  logic [N*32-1:0] period_in, duty_in, control_in;
  logic         busy, done, err, psel, penable, pwrite;
  logic [31:0]  paddr, pwdata, prdata;

  pwm_cfg_sequencer #(.NUM_CHANNELS(N), .BASE_ADDR(32'h8000_0000), .REGS_PER_CHAN(3)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .chan_mask(chan_mask),
    .period_in(period_in), .duty_in(duty_in), .control_in(control_in),
    .busy(busy), .done(done), .err(err), .paddr(paddr), .pwdata(pwdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .prdata(prdata)
  );

  always #5 clk = ~clk;

  // Simple APB slave memory; inject forces a bad readback of channel 1 duty.
  logic [31:0] mem [16];
  logic        inject;
  always @(posedge clk) if (psel && penable && pwrite) mem[paddr[5:2]] <= pwdata;
  always_comb prdata = (inject && paddr == 32'h8000_0010) ? 32'h0000_DEAD : mem[paddr[5:2]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] per_v [N];
  logic [31:0] duty_v [N];
  logic [31:0] ctl_v [N];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int busy_cnt, done_cyc, n_setup, n_read, pwr_bad, psel_cnt;
  logic err_at_done;

  task automatic load_inputs();
    for (int i = 0; i < N; i++) begin
      period_in[i*32 +: 32]  = per_v[i];
      duty_in[i*32 +: 32]    = duty_v[i];
      control_in[i*32 +: 32] = ctl_v[i];
    end
  endtask

  // Called at a negedge; cycle 1 is the cycle after start is sampled.
  task automatic run_seq(input logic [N-1:0] m, input int mode);
    wr_addr.delete();
    wr_data.delete();
    busy_cnt = 0; done_cyc = -1; n_setup = 0; n_read = 0; pwr_bad = 0; psel_cnt = 0;
    err_at_done = 1'bx;
    start = 1'b1;
    chan_mask = m;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (psel) psel_cnt++;
      if (psel && !pwrite) pwr_bad++;
      if (psel && penable && pwrite) begin
        wr_addr.push_back(paddr);
        wr_data.push_back(pwdata);
      end
      if (psel && !penable && pwrite) n_setup++;
      if (psel && penable && !pwrite) n_read++;
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) begin
        done_cyc = c;
        err_at_done = err;
      end
      if (mode == 1 && c == 3) begin
        period_in = {N{32'h99}};
        duty_in = {N{32'h55}};
        control_in = {N{32'h77}};
        chan_mask = 4'h1;
      end
      start = (mode == 1 && c == 5);
      if (done_cyc > 0 && !busy) break;
      @(negedge clk);
    end
    start = 1'b0;
    $display("seq mask=%h mode=%0d writes=%0d busy=%0d done_at=%0d", m, mode, wr_addr.size(), busy_cnt, done_cyc);
  endtask

  task automatic check_writes(input string tag, input logic [N-1:0] m);
    int n;
    logic [31:0] ea, ed;
    n = 0;
    for (int ch = 0; ch < N; ch++)
      if (m[ch]) n += 3;
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(n));
    n = 0;
    for (int ch = 0; ch < N; ch++) begin
      if (m[ch]) begin
        for (int idx = 0; idx < 3; idx++) begin
          ea = 32'h8000_0000 + 32'((ch * 3 + idx) * 4);
          ed = (idx == 0) ? per_v[ch] : (idx == 1) ? duty_v[ch] : ctl_v[ch];
          if (n < wr_addr.size()) begin
            check($sformatf("%s_addr%0d", tag, n), wr_addr[n], ea);
            check($sformatf("%s_data%0d", tag, n), wr_data[n], ed);
          end
          n++;
        end
      end
    end
  endtask

  logic [31:0] t2_addr [6];
  logic [31:0] t2_data [6];
  int seen;

  initial begin
    n_rst = 1'b0; start = 1'b0; chan_mask = '0; inject = 1'b0;
    per_v  = '{32'd16, 32'd16, 32'd16, 32'd16};
    duty_v = '{32'd10, 32'd8, 32'd4, 32'd1};
    ctl_v  = '{32'd7, 32'd5, 32'd3, 32'd1};
    load_inputs();
    t2_addr = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0018, 32'h8000_001C, 32'h8000_0020};
    t2_data = '{32'd16, 32'd10, 32'd7, 32'd16, 32'd4, 32'd3};
    repeat (3) @(negedge clk);

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_pwrite", 32'(pwrite), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Full mask: 12 writes across channels 0..3
    run_seq(4'hF, 0);
    check("t1_done_cyc", 32'(done_cyc), 32'(CPR * 12 + 1));
    check("t1_busy_cnt", 32'(busy_cnt), 32'(CPR * 12 + 1));
    check("t1_setups", 32'(n_setup), 32'd12);
    check_writes("t1", 4'hF);
    if (wr_addr.size() == 12) check("t1_last_addr", wr_addr[11], 32'h8000_002C);
`ifndef PWM_CFG_VERIFY_EN
    check("t1_pwrite_low", 32'(pwr_bad), 32'd0);
    check("t1_err", 32'(err_at_done), 32'd0);
`endif

    // Sparse mask: channels 0 and 2 only
    run_seq(4'b0101, 0);
    check("t2_done_cyc", 32'(done_cyc), 32'(CPR * 6 + 1));
    check("t2_nwr", 32'(wr_addr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("t2_addr%0d", i), wr_addr[i], t2_addr[i]);
        check($sformatf("t2_data%0d", i), wr_data[i], t2_data[i]);
      end
    end

    // Empty mask: immediate done, no bus activity
    run_seq(4'h0, 0);
    check("t3_done_cyc", 32'(done_cyc), 32'd1);
    check("t3_busy_cnt", 32'(busy_cnt), 32'd1);
    check("t3_psel_cnt", 32'(psel_cnt), 32'd0);

    // Inputs changed at cycle 3 and a second start at cycle 5 must not disturb the run
    run_seq(4'hF, 1);
    check("t4_done_cyc", 32'(done_cyc), 32'(CPR * 12 + 1));
    check_writes("t4", 4'hF);
    repeat (3) @(negedge clk);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_psel", 32'(psel), 32'd0);
    load_inputs();

    // Async reset during the access phase of the fourth write
    start = 1'b1; chan_mask = 4'hF;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (psel && penable && pwrite) seen++;
      if (seen == 4) break;
      @(negedge clk);
    end
    check("t5_reach_w4", 32'(seen), 32'd4);
    n_rst = 1'b0;
    #1;
    check("t5_psel", 32'(psel), 32'd0);
    check("t5_penable", 32'(penable), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    run_seq(4'hF, 0);
    check("t5_done_cyc", 32'(done_cyc), 32'(CPR * 12 + 1));
    check_writes("t5", 4'hF);

`ifdef PWM_CFG_VERIFY_EN
    // Bad readback on channel 1 duty sets a sticky error; the next start clears it
    inject = 1'b1;
    run_seq(4'hF, 0);
    check("v_reads", 32'(n_read), 32'd12);
    check("v_err_done", 32'(err_at_done), 32'd1);
    @(negedge clk);
    check("v_err_sticky", 32'(err), 32'd1);
    inject = 1'b0;
    run_seq(4'hF, 0);
    check("v_err_clear", 32'(err_at_done), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
- APB master that programs the multi-channel PWM peripheral's period, duty and control registers from parallel configuration inputs, triggered by a single start pulse.
- Sits between a configuration source (boot ROM, CSR block or test logic) and the PWM's APB slave port.
- Drives PWM register writes per channel in map order (period, duty, control), so each channel's control (enable) lands after its period and duty.

Parameters:
- NUM_CHANNELS, 4, number of PWM channels; legal 1..8.
- BASE_ADDR, 32'h80000000, APB base address of the PWM slave.
- REGS_PER_CHAN, 3, registers per channel: index 0 period, 1 duty, 2 control.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a programming sequence.
- chan_mask  in  NUM_CHANNELS  1 = program this channel; 0 = skip it.
- period_in  in  NUM_CHANNELS x 32  per-channel period values.
- duty_in  in  NUM_CHANNELS x 32  per-channel duty values.
- control_in  in  NUM_CHANNELS x 32  per-channel control values.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence completion.
- err  out  1  sticky readback mismatch flag (Optional Feature only).
- paddr  out  32  APB address.
- pwdata  out  32  APB write data.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write strobe.
- prdata  in  32  APB read data.

Behaviour:
- Reset: async assertion of n_rst forces state IDLE and clears busy, done, err, psel, penable, pwrite, paddr and pwdata to 0. Reset mid-transfer abandons the transfer immediately; there is no resume.
- All outputs are registered.
- States: IDLE, SETUP, ACCESS, DONE. With the Optional Feature, also RSETUP and RACCESS.
- IDLE:
  - start=1 and chan_mask!=0: snapshot chan_mask and all *_in values into shadow registers, select the lowest set channel with register index 0, go to SETUP.
  - start=1 and chan_mask==0: go to DONE.
  - Input changes after the snapshot have no effect on the running sequence.
- SETUP:
  - psel=1, penable=0, pwrite=1.
  - paddr = BASE_ADDR + (ch*REGS_PER_CHAN + idx)*4.
  - pwdata = shadow value for the current channel and index.
  - Next state: ACCESS.
- ACCESS:
  - psel=1, penable=1; address and data held.
  - If idx<2: idx+1, go to SETUP.
  - Else if another set mask bit exists above ch: advance to the next set bit, idx=0, go to SETUP.
  - Else: go to DONE.
  - psel stays high across back-to-back transfers.
  - Zero wait states; the slave has no pready.
- DONE: psel=penable=pwrite=0, done=1 for exactly one cycle, then IDLE.
- busy is 1 in every state except IDLE; done and busy are both 1 in the DONE cycle.
- Latency: with k set mask bits, the first SETUP is the cycle after start is sampled. The DONE cycle is 6k+1 cycles after start (1 cycle for an empty mask).
- start while busy is ignored; it is not queued.
- Channel index arithmetic uses $clog2(NUM_CHANNELS)+1 bits and never wraps past NUM_CHANNELS-1.
- Outside transfers paddr/pwdata hold their last values; psel=0 qualifies them.

Optional Feature:
- Macro: PWM_CFG_VERIFY_EN.
- When defined, each write ACCESS goes to RSETUP instead of advancing: psel=1, penable=0, pwrite=0, same paddr.
- RSETUP is followed by RACCESS: penable=1. In RACCESS, prdata is compared with the written value; a mismatch sets err, which stays set until the next accepted start or reset. RACCESS then advances exactly as ACCESS does.
- Each register costs 4 cycles, so DONE comes 12k+1 cycles after start.
- When undefined, prdata is ignored, err is tied 0, and pwrite=1 whenever psel=1.

Test Plan:
- Reset, then start with chan_mask=4'hF, period=16, duty={10,8,4,1}, control={7,5,3,1} -> 12 writes to 0x80000000..0x8000002C in order, each 2 cycles (penable low then high). busy is high for 25 cycles, done pulses at cycle 25.
- chan_mask=4'b0101 -> writes only to 0x80000000/04/08 and 0x80000018/1C/20; done at cycle 13.
- chan_mask=0 with start -> no psel activity, done pulses the next cycle, busy high for 1 cycle.
- Second start pulse at cycle 5 of a running sequence, with inputs changed at cycle 3 -> ignored; written data equals the values at the first start.
- Assert n_rst low during the ACCESS of write 4 -> psel/penable/busy drop to 0 asynchronously. After release, a new start runs a full sequence from channel 0.
- With PWM_CFG_VERIFY_EN, bench returns prdata=0xDEAD on the duty readback of channel 1 -> err=1 after that RACCESS and stays 1 through done; the next start clears it.
